// File: rtl/paint_pkg.sv
// Shared definitions for the paint-tool blocks.
//   - state_t      : cursor drawer FSM states
//   - BLINK_W      : width of blink cycle counts
//   - DEF_BLINK_*  : default blink phase lengths, shared by paint blocks
//   - DEF_COLOR_*  : default ON/OFF pixel values
package paint_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BLINK_W = 24;

  localparam logic [BLINK_W-1:0] DEF_BLINK_ON_CYC  = 24'd6000000;
  localparam logic [BLINK_W-1:0] DEF_BLINK_OFF_CYC = 24'd6000000;

  localparam logic [7:0] DEF_COLOR_ON  = 8'hFF;
  localparam logic [7:0] DEF_COLOR_OFF = 8'h00;

endpackage

// File: rtl/blink_timer.sv
// Free-running blink phase generator.
//   clk      : system clock
//   rst      : asynchronous active-low reset (phase ON, count 0)
//   phase_on : 1 for ON_CYC cycles, then 0 for OFF_CYC cycles, repeating
module blink_timer
  import paint_pkg::*;
#(
  parameter logic [BLINK_W-1:0] ON_CYC  = DEF_BLINK_ON_CYC,
  parameter logic [BLINK_W-1:0] OFF_CYC = DEF_BLINK_OFF_CYC
) (
  input  logic clk,
  input  logic rst,
  output logic phase_on
);

  logic [BLINK_W-1:0] cnt;
  logic               phase_end;

  // The count restarts at each phase boundary, so it measures cycles
  // spent in the current phase.
  assign phase_end = phase_on ? (cnt == ON_CYC - 1'b1) : (cnt == OFF_CYC - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else if (phase_end) begin
      cnt      <= '0;
      phase_on <= ~phase_on;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/draw_cursor_sized.sv
// Draws an N x N square cursor into a framebuffer write port.
//   clk, rst          : clock, asynchronous active-low reset
//   init              : start request, accepted in IDLE only
//   in_x, in_y        : top-left anchor of the cursor
//   size              : side length (0 -> 1, above SIZE_MAX -> SIZE_MAX)
//   blink_en          : 1 = colour follows blink phase, 0 = always COLOR_ON
//   wr_ready          : framebuffer accepts the current pixel
//   out_x, out_y      : pixel coordinate being written
//   px_data           : pixel value being written
//   paint             : write valid
//   busy              : high from the cycle after accept through DONE
//   cursor_done       : one-cycle completion pulse
//
// Write handshake: a pixel transfers on a cycle where paint and wr_ready are
// both 1; while paint is 1 and wr_ready is 0, out_x/out_y/px_data are held.
// Pixels falling off the grid are skipped with one paint=0 cycle each.
module draw_cursor_sized
  import paint_pkg::*;
#(
  parameter int                 COORD_W       = 6,
  parameter int                 PX_W          = 8,
  parameter int                 SIZE_MAX      = 4,
  parameter int                 SIZE_W        = 3,
  parameter logic [BLINK_W-1:0] BLINK_ON_CYC  = DEF_BLINK_ON_CYC,
  parameter logic [BLINK_W-1:0] BLINK_OFF_CYC = DEF_BLINK_OFF_CYC,
  parameter logic [PX_W-1:0]    COLOR_ON      = PX_W'(DEF_COLOR_ON),
  parameter logic [PX_W-1:0]    COLOR_OFF     = PX_W'(DEF_COLOR_OFF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [SIZE_W-1:0]  size,
  input  logic               blink_en,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [PX_W-1:0]    px_data,
  output logic               paint,
  output logic               busy,
  output logic               cursor_done
);

  localparam logic [SIZE_W-1:0] N_MAX = SIZE_W'(SIZE_MAX);

  state_t              state, state_nx;
  logic [COORD_W-1:0]  x0, y0;
  logic [SIZE_W-1:0]   n, dx, dy, size_eff;
  logic [PX_W-1:0]     color;
  logic                phase_on;
  logic [COORD_W:0]    sum_x, sum_y;
  logic                clipped, last_px, advance, accept;

  blink_timer #(
    .ON_CYC (BLINK_ON_CYC),
    .OFF_CYC(BLINK_OFF_CYC)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .phase_on(phase_on)
  );

  always_comb begin
    size_eff = size;
    if (size == '0)        size_eff = SIZE_W'(1);
    else if (size > N_MAX) size_eff = N_MAX;
  end

  // One extra bit so a pixel past the right/bottom edge shows up as a carry.
  assign sum_x   = {1'b0, x0} + (COORD_W+1)'(dx);
  assign sum_y   = {1'b0, y0} + (COORD_W+1)'(dy);
  assign clipped = sum_x[COORD_W] | sum_y[COORD_W];
  assign last_px = (dx == n - 1'b1) && (dy == n - 1'b1);
  assign accept  = (state == IDLE) && init;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    advance     = 1'b0;
    paint       = 1'b0;
    out_x       = '0;
    out_y       = '0;
    px_data     = '0;
    busy        = 1'b0;
    cursor_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (init) state_nx = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        if (clipped) begin
          advance = 1'b1;
        end else begin
          paint   = 1'b1;
          out_x   = sum_x[COORD_W-1:0];
          out_y   = sum_y[COORD_W-1:0];
          px_data = color;
          advance = wr_ready;
        end
        if (advance && last_px) state_nx = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        cursor_done = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Draw context is captured once at accept; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0    <= '0;
      y0    <= '0;
      n     <= '0;
      color <= '0;
      dx    <= '0;
      dy    <= '0;
    end else if (accept) begin
      x0    <= in_x;
      y0    <= in_y;
      n     <= size_eff;
      color <= (blink_en && !phase_on) ? COLOR_OFF : COLOR_ON;
      dx    <= '0;
      dy    <= '0;
    end else if (advance) begin
      if (dx == n - 1'b1) begin
        dx <= '0;
        dy <= dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_draw_cursor_sized.sv
module tb_draw_cursor_sized;

  localparam int BON  = 8;
  localparam int BOFF = 8;
  localparam int GRID = 64;
  localparam int EW   = 21;  // {clip, x[5:0], y[5:0], px[7:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init = 1'b0;
  logic [5:0] in_x = '0;
  logic [5:0] in_y = '0;
  logic [2:0] size = '0;
  logic       blink_en = 1'b0;
  logic       wr_ready = 1'b1;
  logic [5:0] out_x, out_y;
  logic [7:0] px_data;
  logic       paint, busy, cursor_done;

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [EW-1:0] exp_q[$];

  draw_cursor_sized #(
    .COORD_W      (6),
    .PX_W         (8),
    .SIZE_MAX     (4),
    .SIZE_W       (3),
    .BLINK_ON_CYC (24'(BON)),
    .BLINK_OFF_CYC(24'(BOFF)),
    .COLOR_ON     (8'hFF),
    .COLOR_OFF    (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .in_x       (in_x),
    .in_y       (in_y),
    .size       (size),
    .blink_en   (blink_en),
    .wr_ready   (wr_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .px_data    (px_data),
    .paint      (paint),
    .busy       (busy),
    .cursor_done(cursor_done)
  );

  // clock / reset-relative cycle counter
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: expected write list for one cursor, in row-major order.
  task automatic build_expect(input int x, input int y, input int sz, input bit ben);
    int n;
    logic [7:0] col;
    n   = (sz == 0) ? 1 : (sz > 4) ? 4 : sz;
    col = (!ben || ((cyc % (BON + BOFF)) < BON)) ? 8'hFF : 8'h00;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        if (x + c >= GRID || y + r >= GRID)
          exp_q.push_back({1'b1, 20'd0});
        else
          exp_q.push_back({1'b0, 6'(x + c), 6'(y + r), col});
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE
  // (or right after asserting reset when abort_at writes have completed).
  task automatic draw(input int x, input int y, input int sz, input bit ben,
                      input int stall, input bit rnd, input bit hold, input int abort_at);
    int writes, n_cyc;
    bit done_seen, aborted;
    logic [EW-1:0] e;
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_out", {paint, cursor_done, out_x, out_y, px_data}, 0);
    build_expect(x, y, sz, ben);
    in_x = 6'(x); in_y = 6'(y); size = 3'(sz); blink_en = ben; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      init = 1'b0;
      in_x = 6'($urandom); in_y = 6'($urandom); size = 3'($urandom); blink_en = 1'($urandom);
    end
    writes = 0; n_cyc = 0; done_seen = 0; aborted = 0;
    while (!done_seen && !aborted && n_cyc < 200) begin
      wr_ready = (n_cyc < stall) ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (exp_q.size() == 0) begin
        check("done_pulse", {cursor_done, paint, busy}, 3'b101);
        done_seen = 1;
      end else begin
        e = exp_q[0];
        check("busy_hi", {cursor_done, busy}, 2'b01);
        if (e[20]) begin
          check("clip_paint", {31'd0, paint}, 0);
          void'(exp_q.pop_front());
        end else if (abort_at == writes) begin
          rst = 1'b0;
          #1;
          check("rst_out", {paint, busy, cursor_done, out_x, out_y, px_data}, 0);
          exp_q.delete();
          aborted = 1;
        end else begin
          check("pixel", {paint, out_x, out_y, px_data}, {1'b1, e[19:0]});
          if (wr_ready) begin
            void'(exp_q.pop_front());
            writes++;
          end
        end
      end
      if (!aborted) begin
        n_cyc++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("finished", {31'd0, done_seen | aborted}, 1);
    wr_ready = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    init = 1'b0;
    rst  = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_hold", {paint, busy, cursor_done, out_x, out_y, px_data}, 0);
    end
    rst = 1'b1;
  endtask

  initial begin
    do_reset(3);
    @(negedge clk);

    // basic 2x2, blink off
    draw(10, 20, 2, 0, 0, 0, 0, -1);
    // bottom-right corner clipping
    draw(62, 63, 4, 0, 0, 0, 0, -1);

    // blink phase: OFF at cycle 10, ON at cycle 18
    @(negedge clk);
    do_reset(2);
    while (cyc != 10) @(negedge clk);
    draw(5, 5, 2, 1, 0, 0, 0, -1);
    while (cyc != 18) @(negedge clk);
    draw(5, 5, 2, 1, 0, 0, 0, -1);

    // single pixel with 3-cycle stall
    draw(30, 30, 1, 0, 3, 0, 0, -1);
    // size 0 -> 1, size 7 -> 4
    draw(0, 0, 0, 0, 0, 0, 0, -1);
    draw(1, 2, 7, 0, 0, 1, 0, -1);

    // init held through DONE: ignored there, accepted on the next IDLE cycle
    draw(40, 40, 2, 1, 0, 0, 1, -1);
    draw(40, 40, 2, 1, 0, 0, 0, -1);

    // reset during the third pixel of a 3x3 draw
    draw(20, 30, 3, 0, 0, 0, 0, 2);
    do_reset(3);
    @(negedge clk);
    draw(20, 30, 3, 0, 0, 0, 0, -1);

    // randomized draws
    for (int i = 0; i < 30; i++) begin
      int x, y;
      x = $urandom_range(0, 1) ? $urandom_range(56, 63) : $urandom_range(0, 63);
      y = $urandom_range(0, 1) ? $urandom_range(56, 63) : $urandom_range(0, 63);
      repeat ($urandom_range(0, 9)) @(negedge clk);
      draw(x, y, $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 2), 1'($urandom), 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
